seg_scan_decoder: RTL and testbench
===================================

// Module: seg_scan_decoder
// PURPOSE
//  Monitors a multiplexed 7-segment display bus (active-low digit enables + active-low
//  segments) and recovers the hex value shown on each digit. Sits beside the display
//  driver as a self-check/readback path: the decoded word is compared against the
//  register that was sent to the display, on-chip or through the debug port.
//  Decoding starts only after a pattern has been stable, so ghosting at digit switch is ignored.
// PARAMETERS
//  DIGITS         4   number of multiplexed digits (1..8)
//  STABLE_CYCLES  8   consecutive identical samples required before capture (2..255)
// PORTS
//  clk          in   1          system clock, all logic on rising edge
//  rst          in   1          synchronous, active-high reset
//  an           in   DIGITS     digit enables, active-low; an[i]=0 selects digit i
//  seg          in   7          segments {g,f,e,d,c,b,a}, active-low
//  clear        in   1          synchronous clear of captured state (same effect as rst)
//  word_out     out  4*DIGITS   decoded value; digit i in word_out[4i+3:4i]
//  digit_valid  out  DIGITS     bit i set once digit i has captured a legal pattern
//  err_pattern  out  DIGITS     bit i set (sticky) if digit i showed an illegal pattern
//  frame_done   out  1          one-cycle pulse: every digit captured since last pulse
// BEHAVIOUR
//  Reset/clear: word_out=0, digit_valid=0, err_pattern=0, frame_done=0, seen mask=0,
//   stability counter=0, sample register=all ones (blank). clear has priority over capture.
//  Decode table (seg -> nibble), hex: 40->0 79->1 24->2 30->3 19->4 12->5 02->6 78->7
//   00->8 10->9 08->A 03->B 46->C 21->D 06->E 0E->F; any other value is illegal.
//  Input stage: {an,seg} registered every cycle (sample). Counter increments, saturating
//   at STABLE_CYCLES, while sample equals previous sample; resets to 1 on any change.
//  Capture fires exactly once per stable period, when counter reaches STABLE_CYCLES:
//   input held constant from before edge k -> outputs updated after edge k+STABLE_CYCLES.
//   No re-capture until the sample changes and stabilises again.
//  Capture rules:
//   - an not one-hot low (all high, or >1 low): ignored, nothing updated.
//   - legal pattern: word_out nibble i <= decode; digit_valid[i] <= 1; seen[i] <= 1.
//   - illegal pattern: err_pattern[i] <= 1; nibble i and digit_valid[i] unchanged;
//     seen[i] <= 1 (digit was scanned).
//  Frame FSM: SCAN -> DONE when seen becomes all ones; DONE lasts one cycle: frame_done=1,
//   seen <= 0 (a capture in that same cycle is kept in the new seen mask), -> SCAN.
//  Same digit re-captured before frame completes: nibble overwritten, seen unchanged.
//  Change of an or seg mid-count: counter restarts, no partial capture.
//  rst/clear mid-count: all state to reset values; pending capture is discarded.
//  Widths: counter 8 bits, saturates; DIGITS=1 gives frame_done on every legal/illegal capture.
// TESTING
//  1 rst; an=1110 seg=30 for 8 cycles -> word_out[3:0]=3, digit_valid=0001 exactly at edge+8.
//  2 scan digits 0..3 with 1,2,A,F (8+ cycles each) -> word_out=F A 2 1 (=16'hFA21), one frame_done pulse.
//  3 an=1101 seg=7F held 20 cycles -> err_pattern=0010, word_out unchanged, digit_valid[1]=0.
//  4 seg toggles 40/79 every 3 cycles on digit 0 (STABLE=8) -> no capture, outputs stay at reset.
//  5 an=1100 (two low) seg=00 held 20 cycles -> no change; then an=1111 -> still no change.
//  6 assert clear at capture edge of digit 2 -> word_out=0, digit_valid=0, seen restarted.

Source files
------------

// File: rtl/seg_scan_if.sv
// seg_scan_if: display bus probe plus decoded readback signals
interface seg_scan_if #(parameter int DIGITS = 4) ();
  logic [DIGITS-1:0]   an;
  logic [6:0]          seg;
  logic                clear;
  logic [4*DIGITS-1:0] word_out;
  logic [DIGITS-1:0]   digit_valid;
  logic [DIGITS-1:0]   err_pattern;
  logic                frame_done;
  modport master (output an, seg, clear, input word_out, digit_valid, err_pattern, frame_done);
  modport slave  (input an, seg, clear, output word_out, digit_valid, err_pattern, frame_done);
endinterface

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers hex digits from a multiplexed active-low 7-segment bus
module seg_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 8
) (
  input logic        clk,
  input logic        rst,
  seg_scan_if.slave  bus
);
  typedef enum logic {SCAN, DONE} state_t;
  state_t              state, state_n;
  logic [DIGITS+6:0]   smp;
  logic [7:0]          cnt;
  logic                armed;
  logic [4*DIGITS-1:0] word;
  logic [DIGITS-1:0]   valid, err, seen, cap;
  logic [3:0]          dec;
  logic                legal, clr, chg, fire;
  logic [DIGITS-1:0]   s_an;
  logic [6:0]          s_seg;
  assign clr   = rst | bus.clear;
  assign s_an  = smp[DIGITS+6:7];
  assign s_seg = smp[6:0];
  assign chg   = {bus.an, bus.seg} != smp;
  assign fire  = armed && cnt == 8'(STABLE_CYCLES);
  assign cap   = (fire && $onehot(~s_an)) ? ~s_an : '0;
  // segment pattern to nibble; anything off-table is flagged illegal
  always_comb begin
    dec   = 4'h0;
    legal = 1'b1;
    case (s_seg)
      7'h40: dec = 4'h0;
      7'h79: dec = 4'h1;
      7'h24: dec = 4'h2;
      7'h30: dec = 4'h3;
      7'h19: dec = 4'h4;
      7'h12: dec = 4'h5;
      7'h02: dec = 4'h6;
      7'h78: dec = 4'h7;
      7'h00: dec = 4'h8;
      7'h10: dec = 4'h9;
      7'h08: dec = 4'hA;
      7'h03: dec = 4'hB;
      7'h46: dec = 4'hC;
      7'h21: dec = 4'hD;
      7'h06: dec = 4'hE;
      7'h0E: dec = 4'hF;
      default: legal = 1'b0;
    endcase
  end
  // sample the bus and count how long it has been stable; one capture per stable period
  always_ff @(posedge clk) begin
    if (clr) begin
      smp   <= '1;
      cnt   <= 8'd0;
      armed <= 1'b1;
    end else begin
      smp   <= {bus.an, bus.seg};
      cnt   <= chg ? 8'd1 : (cnt == 8'(STABLE_CYCLES) ? cnt : cnt + 8'd1);
      armed <= chg ? 1'b1 : (fire ? 1'b0 : armed);
    end
  end
  // apply a capture to the selected digit's nibble, valid and error flags
  always_ff @(posedge clk) begin
    if (clr) begin
      word  <= '0;
      valid <= '0;
      err   <= '0;
    end else begin
      for (int i = 0; i < DIGITS; i++)
        if (cap[i] && legal) word[4*i +: 4] <= dec;
      valid <= valid | (legal ? cap : '0);
      err   <= err | (legal ? '0 : cap);
    end
  end
  // frame state register and seen mask; a capture during DONE seeds the next frame
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= SCAN;
      seen  <= '0;
    end else begin
      state <= state_n;
      seen  <= state == DONE ? cap : seen | cap;
    end
  end
  // leave SCAN once every digit has been scanned; DONE lasts a single cycle
  always_comb state_n = (state == SCAN && &seen) ? DONE : SCAN;
  assign bus.word_out    = word;
  assign bus.digit_valid = valid;
  assign bus.err_pattern = err;
  assign bus.frame_done  = state == DONE;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: scoreboard bench for the 7-segment readback decoder
module tb_seg_scan_decoder;
  localparam int STABLE = 8;
  typedef struct {logic [15:0] w; logic [3:0] v; logic [3:0] e;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int frames = 0;
  exp_t sb[$];
  logic [15:0] m_word;
  logic [3:0]  m_valid, m_err;
  logic [6:0]  codes [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  seg_scan_if #(.DIGITS(4)) bus ();
  seg_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(STABLE)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.frame_done === 1'b1) frames++;
  task automatic model_reset();
    m_word = '0;
    m_valid = '0;
    m_err = '0;
  endtask
  task automatic compare(input string name, input exp_t x);
    total += 3;
    if (bus.word_out !== x.w) begin
      bad++;
      $display("FAIL %s word_out got=%h want=%h", name, bus.word_out, x.w);
    end
    if (bus.digit_valid !== x.v) begin
      bad++;
      $display("FAIL %s digit_valid got=%b want=%b", name, bus.digit_valid, x.v);
    end
    if (bus.err_pattern !== x.e) begin
      bad++;
      $display("FAIL %s err_pattern got=%b want=%b", name, bus.err_pattern, x.e);
    end
  endtask
  task automatic hold(input string name, input logic [3:0] a, input logic [6:0] s, input int n);
    int d, k;
    @(negedge clk);
    bus.an = a;
    bus.seg = s;
    if (n >= STABLE && $countones(~a) == 1) begin
      d = 0;
      for (int i = 0; i < 4; i++) if (!a[i]) d = i;
      k = -1;
      for (int i = 0; i < 16; i++) if (codes[i] == s) k = i;
      if (k >= 0) begin
        m_word[4*d +: 4] = 4'(k);
        m_valid[d] = 1'b1;
      end else m_err[d] = 1'b1;
    end
    sb.push_back('{m_word, m_valid, m_err});
    repeat (n) @(negedge clk);
    compare(name, sb.pop_front());
  endtask
  task automatic blank_clear();
    @(negedge clk);
    bus.an = '1;
    bus.seg = '1;
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    model_reset();
  endtask
  task automatic check_frames(input string name, input int want);
    total++;
    if (frames !== want) begin
      bad++;
      $display("FAIL %s frame_done pulses got=%0d want=%0d", name, frames, want);
    end
  endtask
  task automatic test_reset();
    bus.an = 4'b0110;
    bus.seg = 7'h00;
    bus.clear = 1'b0;
    rst = 1'b1;
    repeat (12) @(negedge clk);
    bus.an = '1;
    bus.seg = '1;
    model_reset();
    compare("reset", '{16'h0, 4'h0, 4'h0});
    total++;
    if (bus.frame_done !== 1'b0) begin
      bad++;
      $display("FAIL reset frame_done got=%b want=0", bus.frame_done);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_capture_timing();
    @(negedge clk);
    bus.an = 4'b1110;
    bus.seg = 7'h30;
    sb.push_back('{16'h0, 4'h0, 4'h0});
    m_word[3:0] = 4'h3;
    m_valid[0] = 1'b1;
    sb.push_back('{m_word, m_valid, m_err});
    repeat (STABLE) @(negedge clk);
    compare("timing_edge7", sb.pop_front());
    @(negedge clk);
    compare("timing_edge8", sb.pop_front());
    repeat (4) @(negedge clk);
    compare("timing_once", '{m_word, m_valid, m_err});
  endtask
  task automatic test_frame();
    int f0;
    blank_clear();
    f0 = frames;
    hold("frame_d0", 4'b1110, 7'h79, 10);
    hold("frame_d1", 4'b1101, 7'h24, 10);
    hold("frame_d2", 4'b1011, 7'h08, 10);
    hold("frame_d3", 4'b0111, 7'h0E, 10);
    repeat (4) @(negedge clk);
    compare("frame_word", '{16'hFA21, 4'hF, 4'h0});
    check_frames("frame_pulse", f0 + 1);
  endtask
  task automatic test_back_to_back();
    int f0;
    f0 = frames;
    hold("b2b_d0_5", 4'b1110, 7'h12, 10);
    hold("b2b_d0_0", 4'b1110, 7'h40, 10);
    repeat (3) @(negedge clk);
    check_frames("b2b_no_frame", f0);
  endtask
  task automatic test_illegal();
    blank_clear();
    hold("illegal_d1", 4'b1101, 7'h7F, 20);
  endtask
  task automatic test_bad_an();
    hold("two_low", 4'b1100, 7'h00, 20);
    hold("none_low", 4'b1111, 7'h00, 20);
  endtask
  task automatic test_toggle();
    blank_clear();
    for (int i = 0; i < 8; i++) hold("toggle", 4'b1110, i[0] ? 7'h79 : 7'h40, 3);
  endtask
  task automatic test_clear_at_capture();
    int f0;
    blank_clear();
    hold("clr_d0", 4'b1110, 7'h79, 10);
    @(negedge clk);
    bus.an = 4'b1011;
    bus.seg = 7'h24;
    repeat (STABLE) @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    model_reset();
    compare("clr_edge", '{16'h0, 4'h0, 4'h0});
    f0 = frames;
    hold("clr_d1", 4'b1101, 7'h19, 10);
    hold("clr_d2", 4'b1011, 7'h02, 10);
    hold("clr_d3", 4'b0111, 7'h46, 10);
    repeat (3) @(negedge clk);
    check_frames("clr_seen_restart", f0);
    hold("clr_d0b", 4'b1110, 7'h21, 10);
    repeat (3) @(negedge clk);
    check_frames("clr_frame_after", f0 + 1);
    compare("clr_word", '{16'hC64D, 4'hF, 4'h0});
  endtask
  initial begin
    test_reset();
    test_capture_timing();
    test_frame();
    test_back_to_back();
    test_illegal();
    test_bad_an();
    test_toggle();
    test_clear_at_capture();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
